// File: rtl/fp_align_seq_if.sv
// Operand/result bundle between the operand source, the alignment sequencer and the mantissa adder.
// The master side drives operands and accepts results; the slave side is the sequencer.
interface fp_align_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  exp_out;
  logic [26:0] mant_big;
  logic [26:0] mant_small;
  logic        sign_big;
  logic        sign_small;
  logic        swap;
  logic [4:0]  shift_amt;

  modport master (
    output in_valid, op_a, op_b, out_ready,
    input  in_ready, out_valid, exp_out, mant_big, mant_small,
           sign_big, sign_small, swap, shift_amt
  );

  modport slave (
    input  in_valid, op_a, op_b, out_ready,
    output in_ready, out_valid, exp_out, mant_big, mant_small,
           sign_big, sign_small, swap, shift_amt
  );
endinterface

// File: rtl/fp_align_seq.sv
// Aligns the smaller FP32 operand to the larger one, 1 bit/cycle with GRS; result 2+shift_amt cycles after accept.
// One op in flight: in_ready only in IDLE; the result holds in DONE for as long as out_ready stays low.
module fp_align_seq #(
  parameter int MAX_SHIFT = 27
) (
  input  logic          clk,
  input  logic          rstn,
  fp_align_seq_if.slave bus
);

  localparam logic [7:0] MAX_SHIFT_E = 8'(MAX_SHIFT);
  localparam logic [4:0] MAX_SHIFT_C = 5'(MAX_SHIFT);

  typedef enum logic [1:0] {
    IDLE,
    CMP,
    SHIFT,
    DONE
  } state_t;

  state_t      state_q;
  state_t      state_d;

  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [4:0]  count_q;
  logic [7:0]  exp_q;
  logic [26:0] mant_big_q;
  logic [26:0] mant_small_q;
  logic        sign_big_q;
  logic        sign_small_q;
  logic        swap_q;
  logic [4:0]  shift_amt_q;

  logic        accept;
  logic [7:0]  ea;
  logic [7:0]  eb;
  logic [7:0]  diff;
  logic        swap_c;
  logic [26:0] ma;
  logic [26:0] mb;
  logic [4:0]  cnt_c;

  assign accept = bus.in_valid && (state_q == IDLE);

  // Compare stage works on the registered operands; denormals use effective exponent 1.
  always_comb begin
    ea     = (a_q[30:23] == 8'd0) ? 8'd1 : a_q[30:23];
    eb     = (b_q[30:23] == 8'd0) ? 8'd1 : b_q[30:23];
    swap_c = (eb > ea);
    diff   = swap_c ? (eb - ea) : (ea - eb);
    ma     = {(a_q[30:23] != 8'd0), a_q[22:0], 3'b000};
    mb     = {(b_q[30:23] != 8'd0), b_q[22:0], 3'b000};
    cnt_c  = (diff > MAX_SHIFT_E) ? MAX_SHIFT_C : diff[4:0];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid) state_d = CMP;
      CMP:     state_d = (cnt_c == 5'd0) ? DONE : SHIFT;
      SHIFT:   if (count_q <= 5'd1) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_q          <= '0;
      b_q          <= '0;
      count_q      <= '0;
      exp_q        <= '0;
      mant_big_q   <= '0;
      mant_small_q <= '0;
      sign_big_q   <= 1'b0;
      sign_small_q <= 1'b0;
      swap_q       <= 1'b0;
      shift_amt_q  <= '0;
    end else begin
      if (accept) begin
        a_q <= bus.op_a;
        b_q <= bus.op_b;
      end
      if (state_q == CMP) begin
        swap_q       <= swap_c;
        exp_q        <= swap_c ? eb : ea;
        mant_big_q   <= swap_c ? mb : ma;
        mant_small_q <= swap_c ? ma : mb;
        sign_big_q   <= swap_c ? b_q[31] : a_q[31];
        sign_small_q <= swap_c ? a_q[31] : b_q[31];
        count_q      <= cnt_c;
        shift_amt_q  <= cnt_c;
      end
      // Bits falling off the bottom are OR-ed into the sticky position.
      if (state_q == SHIFT) begin
        mant_small_q <= {1'b0, mant_small_q[26:2], mant_small_q[1] | mant_small_q[0]};
        count_q      <= count_q - 5'd1;
      end
    end
  end

  assign bus.in_ready   = (state_q == IDLE);
  assign bus.out_valid  = (state_q == DONE);
  assign bus.exp_out    = exp_q;
  assign bus.mant_big   = mant_big_q;
  assign bus.mant_small = mant_small_q;
  assign bus.sign_big   = sign_big_q;
  assign bus.sign_small = sign_small_q;
  assign bus.swap       = swap_q;
  assign bus.shift_amt  = shift_amt_q;

endmodule

// File: tb/tb_fp_align_seq.sv
// Directed-vector bench for fp_align_seq; expected results queue up at issue and a monitor checks them on out_valid.
module tb_fp_align_seq;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  fp_align_seq_if ifc ();

  fp_align_seq dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (ifc)
  );

  typedef struct packed {
    logic [7:0]  e;
    logic [26:0] mb;
    logic [26:0] ms;
    logic        sb;
    logic        ss;
    logic        sw;
    logic [4:0]  sh;
    logic [7:0]  lat;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];
  int   total  = 0;
  int   bad    = 0;
  int   cyc    = 0;
  int   n_done = 0;
  int   n_exp  = 0;

  exp_t cur;
  logic have = 1'b0;
  int   acc_c;

  logic [31:0] va[9];
  logic [31:0] vb[9];
  exp_t        ve[9];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t mk(input logic [7:0] e, input logic [26:0] mb, input logic [26:0] ms,
                              input logic sb, input logic ss, input logic sw,
                              input logic [4:0] sh, input logic [7:0] lat);
    exp_t r;
    r.e = e; r.mb = mb; r.ms = ms; r.sb = sb; r.ss = ss; r.sw = sw; r.sh = sh; r.lat = lat;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Monitor: pops on each new result, then re-checks every cycle it is held.
  always @(negedge clk) begin
    if (!rstn) begin
      have = 1'b0;
    end else if (ifc.out_valid) begin
      if (!have) begin
        if (exp_q.size() == 0 || acc_q.size() == 0) begin
          chk("stray_out_valid", 32'(exp_q.size()), 32'd1);
        end else begin
          cur   = exp_q.pop_front();
          acc_c = acc_q.pop_front();
          have  = 1'b1;
          chk("latency", 32'(cyc - acc_c), 32'(cur.lat));
        end
      end
      if (have) begin
        chk("exp_out",    32'(ifc.exp_out),    32'(cur.e));
        chk("mant_big",   32'(ifc.mant_big),   32'(cur.mb));
        chk("mant_small", 32'(ifc.mant_small), 32'(cur.ms));
        chk("sign_big",   32'(ifc.sign_big),   32'(cur.sb));
        chk("sign_small", 32'(ifc.sign_small), 32'(cur.ss));
        chk("swap",       32'(ifc.swap),       32'(cur.sw));
        chk("shift_amt",  32'(ifc.shift_amt),  32'(cur.sh));
        if (ifc.out_ready) begin
          have = 1'b0;
          n_done++;
        end
      end
    end else begin
      have = 1'b0;
    end
  end

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input exp_t e);
    logic ok;
    ok = 1'b0;
    exp_q.push_back(e);
    ifc.op_a     = a;
    ifc.op_b     = b;
    ifc.in_valid = 1'b1;
    for (int k = 0; k < 100 && !ok; k++) begin
      if (ifc.in_ready) begin
        ok = 1'b1;
        acc_q.push_back(cyc);
      end
      @(negedge clk);
    end
    ifc.in_valid = 1'b0;
    n_exp++;
    if (!ok) chk("accept_timeout", 32'(ok), 32'd1);
  endtask

  task automatic wait_done(input int target);
    for (int k = 0; k < 100 && n_done < target; k++) @(negedge clk);
    if (n_done < target) chk("done_timeout", 32'(n_done), 32'(target));
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_in_ready"},   32'(ifc.in_ready),   32'd1);
    chk({tag, "_out_valid"},  32'(ifc.out_valid),  32'd0);
    chk({tag, "_exp_out"},    32'(ifc.exp_out),    32'd0);
    chk({tag, "_mant_big"},   32'(ifc.mant_big),   32'd0);
    chk({tag, "_mant_small"}, 32'(ifc.mant_small), 32'd0);
    chk({tag, "_signs"},      32'({ifc.sign_big, ifc.sign_small}), 32'd0);
    chk({tag, "_swap"},       32'(ifc.swap),       32'd0);
    chk({tag, "_shift_amt"},  32'(ifc.shift_amt),  32'd0);
  endtask

  initial begin
    va[0] = 32'h3F800000; vb[0] = 32'h3F800000; ve[0] = mk(8'h7F, 27'h4000000, 27'h4000000, 0, 0, 0, 5'd0,  8'd2);
    va[1] = 32'h3F800000; vb[1] = 32'h3E800000; ve[1] = mk(8'h7F, 27'h4000000, 27'h1000000, 0, 0, 0, 5'd2,  8'd4);
    va[2] = 32'h3E800000; vb[2] = 32'hBF800000; ve[2] = mk(8'h7F, 27'h4000000, 27'h1000000, 1, 0, 1, 5'd2,  8'd4);
    va[3] = 32'h4B000000; vb[3] = 32'h3F800000; ve[3] = mk(8'h96, 27'h4000000, 27'h0000008, 0, 0, 0, 5'd23, 8'd25);
    va[4] = 32'h64000000; vb[4] = 32'h3F800000; ve[4] = mk(8'hC8, 27'h4000000, 27'h0000001, 0, 0, 0, 5'd27, 8'd29);
    va[5] = 32'h00000001; vb[5] = 32'h00800000; ve[5] = mk(8'h01, 27'h0000008, 27'h4000000, 0, 0, 0, 5'd0,  8'd2);
    va[6] = 32'h41000000; vb[6] = 32'h3F800001; ve[6] = mk(8'h82, 27'h4000000, 27'h0800001, 0, 0, 0, 5'd3,  8'd5);
    va[7] = 32'h40400000; vb[7] = 32'h3FC00000; ve[7] = mk(8'h80, 27'h6000000, 27'h3000000, 0, 0, 0, 5'd1,  8'd3);
    va[8] = 32'hBF800000; vb[8] = 32'h64000000; ve[8] = mk(8'hC8, 27'h4000000, 27'h0000001, 0, 1, 1, 5'd27, 8'd29);

    ifc.in_valid  = 1'b0;
    ifc.op_a      = '0;
    ifc.op_b      = '0;
    ifc.out_ready = 1'b1;

    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    rstn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      send(va[i], vb[i], ve[i]);
      wait_done(n_exp);
    end

    // Backpressure with busy-time input traffic.
    ifc.out_ready = 1'b0;
    send(va[3], vb[3], ve[3]);
    for (int k = 0; k < 60 && !ifc.out_valid; k++) @(negedge clk);
    chk("bp_reached_done", 32'(ifc.out_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(ifc.in_ready), 32'd0);
      chk("bp_out_valid", 32'(ifc.out_valid), 32'd1);
      ifc.in_valid = i[0];
      ifc.op_a     = 32'h3F800000 + 32'(i);
      ifc.op_b     = 32'h00800000;
    end
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release_in_ready", 32'(ifc.in_ready), 32'd1);
    chk("bp_release_out_valid", 32'(ifc.out_valid), 32'd0);
    wait_done(n_exp);
    send(va[1], vb[1], ve[1]);
    wait_done(n_exp);

    // Reset in the middle of a clamped shift.
    send(va[4], vb[4], ve[4]);
    repeat (9) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    chk_idle_outputs("midrst");
    exp_q.delete();
    acc_q.delete();
    n_exp--;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (35) @(negedge clk);
    chk("post_rst_idle", 32'(ifc.out_valid), 32'd0);
    send(va[2], vb[2], ve[2]);
    wait_done(n_exp);

    repeat (5) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    chk("results_seen", 32'(n_done), 32'(n_exp));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
